// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, state type and digit decode for the display scheduler
package display_pkg;

    localparam int DIGITS    = 3;
    localparam int SEG_W     = 7;
    localparam int BLANK_CYC = 2;
    localparam int BRIGHT_W  = 3;
    localparam int SLOT_CYC  = BLANK_CYC + (1 << BRIGHT_W) - 1;
    localparam int KW        = $clog2(SLOT_CYC);
    localparam int DW        = $clog2(DIGITS);

    localparam logic [SEG_W-1:0]  SEG_OFF = 7'b1111111;
    localparam logic [DIGITS-1:0] DIG_OFF = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_DRIVE
    } state_e;

    // Active-low one-hot transistor enable for digit d.
    function automatic logic [DIGITS-1:0] digit_sel(input logic [DW-1:0] d);
        digit_sel = ~(DIGITS'(1) << d);
    endfunction

endpackage

// File: rtl/display_scheduler_scan_timer.sv
// rtl/display_scheduler_scan_timer.sv - slot position counter and digit index with frame-end strobe
module scan_timer
    import display_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          run_i,
    output logic [KW-1:0] k_o,
    output logic [KW-1:0] k_d_o,
    output logic [DW-1:0] digit_d_o,
    output logic          frame_end_o
);

    logic [KW-1:0] k_q, k_d;
    logic [DW-1:0] digit_q, digit_d;
    logic          slot_end;

    // Next-state values are exported so the parent can register outputs aligned to the new position.
    always_comb begin
        slot_end    = (k_q == KW'(SLOT_CYC - 1));
        frame_end_o = slot_end && (digit_q == DW'(DIGITS - 1));
        k_d         = '0;
        digit_d     = '0;
        if (run_i) begin
            if (slot_end) begin
                digit_d = frame_end_o ? '0 : digit_q + 1'b1;
            end else begin
                k_d     = k_q + 1'b1;
                digit_d = digit_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q     <= '0;
            digit_q <= '0;
        end else begin
            k_q     <= k_d;
            digit_q <= digit_d;
        end
    end

    assign k_o       = k_q;
    assign k_d_o     = k_d;
    assign digit_d_o = digit_d;

endmodule

// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - frame-synchronous 7-segment scan with atomic frame commit and brightness
module display_scheduler
    import display_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [BRIGHT_W-1:0]       brightness,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIGITS*SEG_W-1:0]   seg_in,
    output logic [DIGITS-1:0]         transistor,
    output logic [SEG_W-1:0]          d7sp,
    output logic                      frame_done
);

    state_e                    state_q, state_d;
    logic [BRIGHT_W-1:0]       bright_q, bright_d;
    logic [DIGITS*SEG_W-1:0]   active_q, active_d, pend_q, pend_d;
    logic                      pend_valid_q, pend_valid_d;
    logic                      run, commit, lit;
    logic [KW-1:0]             k_q, k_d;
    logic [DW-1:0]             digit_d;
    logic                      frame_end;
    logic [DIGITS-1:0]         transistor_d;
    logic [SEG_W-1:0]          d7sp_d;
    logic                      frame_done_d;

    scan_timer u_scan_timer (
        .clk         (clk),
        .rst         (rst),
        .run_i       (run),
        .k_o         (k_q),
        .k_d_o       (k_d),
        .digit_d_o   (digit_d),
        .frame_end_o (frame_end)
    );

    assign in_ready = !pend_valid_q;

    always_comb begin
        run     = (state_q != ST_IDLE) && enable;
        state_d = ST_IDLE;
        if (enable) begin
            state_d = (k_d < KW'(BLANK_CYC)) ? ST_BLANK : ST_DRIVE;
        end

        bright_d = (k_q == '0) ? brightness : bright_q;

        // Commit reads pend before any same-cycle transfer; a transfer needs pend empty, so they never overlap.
        commit       = run && frame_end && pend_valid_q;
        active_d     = commit ? pend_q : active_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        if (commit) begin
            pend_valid_d = 1'b0;
        end
        if (in_valid && in_ready) begin
            pend_d       = seg_in;
            pend_valid_d = 1'b1;
        end

        lit          = (state_d == ST_DRIVE) && ((k_d - KW'(BLANK_CYC)) < KW'(bright_d));
        transistor_d = lit ? digit_sel(digit_d) : DIG_OFF;
        d7sp_d       = lit ? active_d[digit_d*SEG_W +: SEG_W] : SEG_OFF;
        frame_done_d = (state_d != ST_IDLE) && (digit_d == DW'(DIGITS - 1))
                       && (k_d == KW'(SLOT_CYC - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            bright_q     <= '0;
            active_q     <= '1;
            pend_q       <= '1;
            pend_valid_q <= 1'b0;
            transistor   <= DIG_OFF;
            d7sp         <= SEG_OFF;
            frame_done   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bright_q     <= bright_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            transistor   <= transistor_d;
            d7sp         <= d7sp_d;
            frame_done   <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_display_scheduler.sv
// tb/tb_display_scheduler.sv - directed self-checking bench for display_scheduler
module tb_display_scheduler;

    localparam logic [20:0] SEG_D = {~7'b0110000, ~7'b1101101, ~7'b1111110};
    localparam logic [20:0] SEG_A = {~7'b1110000, ~7'b1111111, ~7'b0110011};
    localparam logic [20:0] SEG_B = {~7'b1111111, ~7'b1111111, ~7'b0111111};
    localparam logic [20:0] SEG_C = {~7'b1111001, ~7'b0110011, ~7'b1011011};
    localparam logic [20:0] SEG_E = {~7'b0000001, ~7'b0000010, ~7'b0000100};

    logic        clk;
    logic        rst;
    logic        enable;
    logic [2:0]  brightness;
    logic        in_valid;
    logic        in_ready;
    logic [20:0] seg_in;
    logic [2:0]  transistor;
    logic [6:0]  d7sp;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    int          n;
    bit          e_run, e_pv, e_xfer;
    logic [2:0]  eb;
    logic [20:0] e_act, e_pend;

    display_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .brightness (brightness),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .seg_in     (seg_in),
        .transistor (transistor),
        .d7sp       (d7sp),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
        end
    endtask

    // One clock: predict the edge's effect, advance, then compare the new cycle.
    task automatic cycle();
        int  k, d;
        bit  old_pv, lit;
        e_xfer = 0;
        old_pv = e_pv;
        if (e_run && enable) begin
            if (n % 9 == 0) eb = brightness;
            if (n % 27 == 26 && e_pv) begin
                e_act = e_pend;
                e_pv  = 0;
            end
        end
        if (in_valid && !old_pv) begin
            e_pend = seg_in;
            e_pv   = 1;
            e_xfer = 1;
        end
        if (enable) begin
            if (e_run) n++;
            else begin
                e_run = 1;
                n     = 0;
            end
        end else begin
            e_run = 0;
            n     = 0;
        end
        @(posedge clk);
        #2;
        k   = n % 9;
        d   = (n / 9) % 3;
        lit = e_run && k >= 2 && (k - 2) < int'(eb);
        check("transistor", transistor,
              lit ? (d == 0 ? 3'b110 : (d == 1 ? 3'b101 : 3'b011)) : 3'b111);
        check("d7sp", d7sp, lit ? e_act[d*7 +: 7] : 7'h7f);
        check("frame_done", frame_done, e_run && k == 8 && d == 2);
        check("in_ready", in_ready, !e_pv);
    endtask

    task automatic run_until(input int modv, input int val, input bit need_empty);
        for (int i = 0; i < 300; i++) begin
            if (e_run && (n % modv) == val && (!need_empty || !e_pv)) return;
            cycle();
        end
        check("run_until_timeout", 0, 1);
    endtask

    initial begin
        enable     = 1'b0;
        in_valid   = 1'b0;
        brightness = 3'd7;
        seg_in     = '0;
        rst        = 1'b0;
        n = 0; e_run = 0; e_pv = 0; e_xfer = 0; eb = 3'd0;
        e_act = '1; e_pend = '1;

        #12;
        check("rst_transistor", transistor, 3'b111);
        check("rst_d7sp", d7sp, 7'h7f);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_frame_done", frame_done, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) cycle();

        // Push while idle: held pending, in_ready low until the first frame end.
        seg_in   = SEG_D;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("idle_ready_low", in_ready, 1'b0);
        repeat (3) cycle();

        enable = 1'b1;
        for (int i = 0; i < 54; i++) begin
            cycle();
            if (n == 0)  check("first_blank_t", transistor, 3'b111);
            if (n == 2)  check("f0_old_seg", d7sp, 7'h7f);
            if (n == 26) check("f0_ready", in_ready, 1'b0);
            if (n == 26) check("f0_done", frame_done, 1'b1);
            if (n == 27) check("f1_ready", in_ready, 1'b1);
            if (n == 29) check("f1_d0", d7sp, 7'b0000001);
            if (n == 38) check("f1_d1", d7sp, 7'b0010010);
            if (n == 47) check("f1_d2", d7sp, 7'b1001111);
            if (n == 53) check("f1_done", frame_done, 1'b1);
        end

        // Brightness 3, then a mid-slot change that must wait for the next slot.
        brightness = 3'd3;
        for (int i = 0; i < 18; i++) begin
            cycle();
            if (n == 57) check("b3_lit", transistor, 3'b110);
            if (n == 59) begin
                check("b3_dark_k5", transistor, 3'b111);
                brightness = 3'd7;
            end
            if (n == 61) check("b3_dark_k7", transistor, 3'b111);
            if (n == 70) check("b7_next_slot", transistor, 3'b101);
        end

        run_until(27, 26, 0);
        brightness = 3'd0;
        for (int i = 0; i < 54; i++) begin
            cycle();
            check("b0_dark", transistor, 3'b111);
        end
        brightness = 3'd7;

        // Back-to-back pushes.
        run_until(27, 5, 1);
        seg_in   = SEG_A;
        in_valid = 1'b1;
        cycle();
        seg_in = SEG_B;
        check("b2b_ready", in_ready, 1'b0);
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (e_xfer) break;
        end
        if (!e_xfer) check("b2b_timeout", 0, 1);
        in_valid = 1'b0;

        // Push during the frame_done cycle commits one frame later.
        run_until(27, 26, 1);
        seg_in   = SEG_C;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 54; i++) begin
            cycle();
            if (n % 27 == 2 && i < 27) check("fd_push_old", d7sp, 7'b1000000);
            if (n % 27 == 2 && i >= 27) check("fd_push_new", d7sp, 7'b0100100);
        end

        // Enable drop at digit 1, k=4.
        run_until(27, 13, 0);
        enable = 1'b0;
        cycle();
        check("drop_t", transistor, 3'b111);
        check("drop_fd", frame_done, 1'b0);
        repeat (30) cycle();
        enable = 1'b1;
        cycle();
        check("restart_blank0", transistor, 3'b111);
        cycle();
        check("restart_blank1", transistor, 3'b111);
        cycle();
        check("restart_lit", transistor, 3'b110);

        // Asynchronous reset mid-DRIVE with pend full.
        run_until(27, 1, 1);
        seg_in   = SEG_E;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        run_until(9, 5, 0);
        check("pre_arst_ready", in_ready, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        check("arst_t", transistor, 3'b111);
        check("arst_d7sp", d7sp, 7'h7f);
        check("arst_ready", in_ready, 1'b1);
        check("arst_fd", frame_done, 1'b0);
        e_run = 0; e_pv = 0; e_act = '1; n = 0;
        @(posedge clk);
        #2;
        check("arst_hold_t", transistor, 3'b111);
        rst = 1'b1;
        for (int i = 0; i < 54; i++) begin
            cycle();
            if (n == 2)  check("post_arst_t", transistor, 3'b110);
            if (n == 2)  check("post_arst_seg", d7sp, 7'h7f);
            if (n == 29) check("post_arst_seg_f1", d7sp, 7'h7f);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog n=%0d", n);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Frame-synchronous scan controller for the three-digit multiplexed 7-segment display. It accepts a new set of three active-low segment patterns through a valid/ready handshake and holds it in a pending buffer. The pending set is committed atomically at frame boundaries, so a displayed frame never mixes old and new digits. Each digit slot is sequenced with dead-time blanking (anti-ghosting) and a brightness on-time. The block replaces the free-running scan stage between the segment-table stage and the pads.

## Interface
- DIGITS, 3, number of multiplexed digits
- SEG_W, 7, segment bits per digit (A..G, active-low)
- BLANK_CYC, 2, dead-time cycles at the start of every digit slot
- BRIGHT_W, 3, brightness width; drive window = 2^BRIGHT_W-1 cycles
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- enable  in  1  scan enable; low forces display dark
- brightness  in  BRIGHT_W  on-cycles per slot; 0 = dark, max = full window
- in_valid  in  1  seg_in valid
- in_ready  out  1  pending buffer free
- seg_in  in  DIGITS*SEG_W  digit i pattern at [i*SEG_W +: SEG_W]; digit 0 = units
- transistor  out  DIGITS  digit enables, active-low, at most one bit low
- d7sp  out  SEG_W  segment drive, active-low
- frame_done  out  1  one-cycle pulse on the last cycle of each frame

## Operation
- Derived constants: SLOT_CYC = BLANK_CYC + 2^BRIGHT_W - 1 (default 9); frame = DIGITS*SLOT_CYC (default 27).
- FSM states: IDLE, BLANK, DRIVE.
  - IDLE → BLANK (digit 0, k=0) when enable=1.
  - In BLANK or DRIVE, any cycle with enable=0 → IDLE, digit index cleared.
- Slot counter k runs 0..SLOT_CYC-1. Digit index advances 0→1→…→DIGITS-1→0 when k wraps.
- State by slot position:
  - k < BLANK_CYC: BLANK.
  - k ≥ BLANK_CYC: DRIVE.
- Within DRIVE, the digit is lit only when (k-BLANK_CYC) < bright_q. Otherwise the outputs are dark.
- bright_q samples brightness at k=0 of every slot. Mid-slot changes are ignored.
- Lit outputs:
  - transistor has only bit d low: d=0 → 3'b110, d=1 → 3'b101, d=2 → 3'b011.
  - d7sp = active[d].
- Dark outputs: transistor all ones, d7sp all ones.
- Handshake:
  - in_ready = !pend_valid.
  - Transfer on in_valid & in_ready: seg_in is copied to pend, and pend_valid is set.
  - seg_in is ignored when in_ready=0.
- Commit: at the end edge of the last cycle of digit DIGITS-1, if pend_valid, then active ← pend and pend_valid ← 0.
  - The commit uses the pend contents from before that edge.
  - A transfer in the same cycle lands in pend and commits at the next frame end.
- While IDLE, no commit occurs and pend is held. in_ready stays low if pend is full.

## Timing
- Reset values:
  - transistor = all ones, d7sp = all ones, frame_done = 0, in_ready = 1.
  - active = all ones, pend_valid = 0, state IDLE, k = 0, digit = 0, bright_q = 0.
- transistor, d7sp and frame_done are flops. Their value in a cycle is the decode of that cycle's (state, digit, k).
- Edge at which enable=1 is first sampled in IDLE: the next cycle is BLANK, digit 0, k=0, outputs dark.
- First lit cycle: k=BLANK_CYC of digit 0, i.e. BLANK_CYC+1 cycles after enable was sampled.
- frame_done is high exactly in cycle digit=DIGITS-1, k=SLOT_CYC-1, once per frame.
- in_ready falls the cycle after a transfer. It rises the cycle after the commit edge.
- enable=0 in any cycle: outputs are dark from the next cycle, and no frame_done is issued for the truncated frame.
- Asynchronous reset mid-frame: outputs go dark immediately and pend is discarded.

## Structure
- Package display_pkg holds:
  - state enum (IDLE, BLANK, DRIVE);
  - SEG_OFF = 7'b1111111;
  - DIG_OFF = 3'b111;
  - digit-select function d → active-low one-hot.
- Sub-module scan_timer owns the slot counter k, the digit index, the wrap and the frame-end strobes. Parent display_scheduler owns the FSM, buffers, handshake and output decode.

## Test plan
- Reset check: with rst low, transistor=111, d7sp=1111111, in_ready=1, frame_done=0. These hold for 5 cycles after release while enable=0.
- Full-brightness scan: brightness=7, push {d2,d1,d0}={~7'b0110000, ~7'b1101101, ~7'b1111110}.
  - Each 9-cycle slot shows 2 dark cycles then 7 lit cycles: 110/d0, then 101/d1, then 011/d2.
  - Lit cycles of the first frame show 1111111; new data appears only from the second frame.
  - frame_done pulses every 27 cycles.
- Brightness: brightness=3 gives exactly 3 lit cycles at k=2..4 per slot. brightness=0 keeps the display dark forever. A change at k=5 takes effect from the next slot.
- Backpressure/commit:
  - two back-to-back pushes: the second sees in_ready=0 until the frame end;
  - a push in the frame_done cycle commits one frame later;
  - no frame ever mixes digits from two pushes.
- Enable drop at digit 1, k=4: outputs are dark the next cycle with no frame_done. Re-enable restarts at digit 0 with 2 blank cycles.
- Asynchronous reset asserted mid-DRIVE with pend full: outputs go dark without a clock, in_ready=1, and the display stays blank after re-enable.
